// File: rtl/neuron_update_scheduler.sv
// Time-multiplexes one membrane-update datapath across NUM_NEURONS neurons.
// Optional feature macro: REFRACTORY_EN (per-neuron refractory skip counters).
module neuron_update_scheduler #(
    parameter int                 NUM_NEURONS  = 8,
    parameter logic signed [15:0] V_REST       = -16'sd65,
    parameter logic signed [15:0] V_THRESH     = 16'sd30,
    parameter logic signed [15:0] V_RESET      = -16'sd65,
    parameter int                 FIFO_DEPTH   = 4,
    parameter int                 REFRAC_TICKS = 3,
    localparam int                IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tick,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        cur_addr,
    input  logic signed [15:0]      cur_data,
    output logic                    dp_req,
    output logic signed [15:0]      dp_v,
    output logic signed [15:0]      dp_i,
    input  logic                    dp_ack,
    input  logic signed [15:0]      dp_v_next,
    output logic                    spk_valid,
    output logic [IDX_W-1:0]        spk_id,
    input  logic                    spk_ready,
    output logic                    spk_drop,
    output logic                    tick_overrun
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW    = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_COMMIT
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic signed [15:0] v_q [NUM_NEURONS];
    logic signed [15:0] v_d [NUM_NEURONS];
    logic signed [15:0] dpv_q, dpv_d;
    logic signed [15:0] dpi_q, dpi_d;
    logic signed [15:0] vnext_q, vnext_d;
    logic               ovr_q, ovr_d;

`ifdef REFRACTORY_EN
    localparam int RC_W = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;
    logic [RC_W-1:0] rc_q [NUM_NEURONS];
    logic [RC_W-1:0] rc_d [NUM_NEURONS];
    logic            skip_q, skip_d;
`endif

    logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
    logic [IDX_W-1:0] fifo_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic             drop_q, drop_d;

    logic last;
    logic spike;
    logic push;
    logic pop;
    logic full;
    logic empty;

    assign last = (idx_q == IDX_W'(NUM_NEURONS - 1));

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, per-neuron potential updates and handshake outputs
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        v_d     = v_q;
        dpv_d   = dpv_q;
        dpi_d   = dpi_q;
        vnext_d = vnext_q;
        ovr_d   = ovr_q;
        spike   = 1'b0;
        done    = 1'b0;
`ifdef REFRACTORY_EN
        rc_d    = rc_q;
        skip_d  = skip_q;
`endif
        // Any tick not seen in IDLE (including the done cycle) is dropped
        if (tick && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                dpv_d   = v_q[idx_q];
                dpi_d   = cur_data;
                state_d = S_REQ;
`ifdef REFRACTORY_EN
                skip_d = 1'b0;
                if (rc_q[idx_q] != '0) begin
                    rc_d[idx_q] = rc_q[idx_q] - RC_W'(1);
                    skip_d      = 1'b1;
                    state_d     = S_COMMIT;
                end
`endif
            end
            S_REQ: begin
                if (dp_ack) begin
                    vnext_d = dp_v_next;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
`ifdef REFRACTORY_EN
                if (!skip_q) begin
                    spike = (vnext_q >= V_THRESH);
                    v_d[idx_q] = spike ? V_RESET : vnext_q;
                    if (spike) begin
                        rc_d[idx_q] = RC_W'(REFRAC_TICKS);
                    end
                end
`else
                spike = (vnext_q >= V_THRESH);
                v_d[idx_q] = spike ? V_RESET : vnext_q;
`endif
                if (last) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Neuron store, datapath operand latches and sticky overrun flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            dpv_q   <= '0;
            dpi_q   <= '0;
            vnext_q <= '0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i] <= V_REST;
            end
`ifdef REFRACTORY_EN
            skip_q <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                rc_q[i] <= '0;
            end
`endif
        end else begin
            idx_q   <= idx_d;
            dpv_q   <= dpv_d;
            dpi_q   <= dpi_d;
            vnext_q <= vnext_d;
            ovr_q   <= ovr_d;
            v_q     <= v_d;
`ifdef REFRACTORY_EN
            skip_q <= skip_d;
            rc_q   <= rc_d;
`endif
        end
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign push  = spike;
    assign pop   = !empty && spk_ready;

    // Spike FIFO: a pop frees the slot a same-cycle push needs when full
    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        drop_d = drop_q;
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        if (push) begin
            if (!full || pop) begin
                fifo_d[wr_q[PTR_W-1:0]] = idx_q;
                wr_d = wr_q + PW'(1);
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    // Spike FIFO storage and pointers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            drop_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            drop_q <= drop_d;
            fifo_q <= fifo_d;
        end
    end

    assign busy         = (state_q != S_IDLE) && !done;
    assign cur_addr     = idx_q;
    assign dp_req       = (state_q == S_REQ);
    assign dp_v         = dpv_q;
    assign dp_i         = dpi_q;
    assign spk_valid    = !empty;
    assign spk_id       = empty ? '0 : fifo_q[rd_q[PTR_W-1:0]];
    assign spk_drop     = drop_q;
    assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Self-checking bench for neuron_update_scheduler.
// Table of passes plus a scoreboard of expected datapath requests.
module tb_neuron_update_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        busy;
    logic        done;
    logic [2:0]  cur_addr;
    logic [15:0] cur_data;
    logic        dp_req;
    logic [15:0] dp_v;
    logic [15:0] dp_i;
    logic        dp_ack = 1'b1;
    logic [15:0] dp_v_next;
    logic        spk_valid;
    logic [2:0]  spk_id;
    logic        spk_ready = 1'b0;
    logic        spk_drop;
    logic        tick_overrun;

    neuron_update_scheduler dut (
        .clock(clock), .reset(reset), .tick(tick),
        .busy(busy), .done(done),
        .cur_addr(cur_addr), .cur_data(cur_data),
        .dp_req(dp_req), .dp_v(dp_v), .dp_i(dp_i),
        .dp_ack(dp_ack), .dp_v_next(dp_v_next),
        .spk_valid(spk_valid), .spk_id(spk_id), .spk_ready(spk_ready),
        .spk_drop(spk_drop), .tick_overrun(tick_overrun)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Current source: neuron k drives 3k+1, unique per neuron
    assign cur_data = 16'(cur_addr) * 16'd3 + 16'd1;

    // Datapath model: +10 per update, or forced to threshold for masked neurons
    logic [7:0] mask = 8'h00;
    always_comb begin
        dp_v_next = dp_v + 16'd10;
        for (int i = 0; i < 8; i++) begin
            if (mask[i] && dp_i == 16'(i * 3 + 1)) dp_v_next = 16'd30;
        end
    end

    typedef struct {
        int          idx;
        logic [15:0] v;
        logic [15:0] i;
    } req_t;

    req_t               sb[$];
    int                 spk_q[$];
    logic signed [15:0] ref_v[8];
    int                 ref_rc[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            ref_v[i] = -16'sd65;
            ref_rc[i] = 0;
        end
        sb.delete();
        spk_q.delete();
    endtask

    // Scoreboard monitor: every transfer must match the next expected request
    always @(negedge clock) begin : mon
        req_t e;
        logic signed [15:0] nv;
        if (!reset && dp_req && dp_ack) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got dp_v=%0h dp_i=%0h want no request", dp_v, dp_i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("dp_v[%0d]", e.idx), 32'(dp_v), 32'(e.v));
                chk($sformatf("dp_i[%0d]", e.idx), 32'(dp_i), 32'(e.i));
                nv = mask[e.idx] ? 16'sd30 : ref_v[e.idx] + 16'sd10;
                if (nv >= 16'sd30) begin
                    ref_v[e.idx] = -16'sd65;
                    ref_rc[e.idx] = 3;
                    if (spk_q.size() < 4) spk_q.push_back(e.idx);
                end else begin
                    ref_v[e.idx] = nv;
                end
            end
        end
    end

    // One update pass; ovr_at>0 pulses a second tick at that cycle of the pass
    task automatic run_pass(input logic [7:0] m, input int ovr_at);
        int exp_cyc;
        int n;
        req_t r;
        mask = m;
        exp_cyc = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef REFRACTORY_EN
            if (ref_rc[i] != 0) begin
                ref_rc[i]--;
                exp_cyc += 2;
                continue;
            end
`endif
            r.idx = i;
            r.v = ref_v[i];
            r.i = 16'(i * 3 + 1);
            sb.push_back(r);
            exp_cyc += 3;
        end
        @(posedge clock); #1 tick = 1'b1;
        @(posedge clock); #1 tick = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            @(posedge clock); #1;
            n++;
            tick = (n == ovr_at);
        end
        tick = 1'b0;
        chk("pass_cycles", 32'(n), 32'(exp_cyc));
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clock); #1;
    endtask

    // Pop everything queued, checking order against the model
    task automatic drain(input int exp_n);
        int cnt;
        cnt = 0;
        spk_ready = 1'b1;
        while (spk_valid && cnt < 8) begin
            if (spk_q.size() == 0) begin
                chk("spk_extra", 32'(spk_id), 32'hFFFF_FFFF);
            end else begin
                chk("spk_id", 32'(spk_id), 32'(spk_q[0]));
                void'(spk_q.pop_front());
            end
            cnt++;
            @(posedge clock); #1;
        end
        spk_ready = 1'b0;
        chk("spk_count", 32'(cnt), 32'(exp_n));
    endtask

    typedef struct {
        logic [7:0] mask;
        int         exp_queued;
        logic       exp_drop;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{8'h00, 0, 1'b0};
        tbl[1]  = '{8'h00, 0, 1'b0};
        tbl[2]  = '{8'h20, 1, 1'b0};
        tbl[3]  = '{8'h00, 0, 1'b0};
        tbl[4]  = '{8'hFF, 4, 1'b1};
        tbl[5]  = '{8'h00, 0, 1'b1};
        tbl[6]  = '{8'h00, 0, 1'b1};
        tbl[7]  = '{8'h00, 0, 1'b1};
        tbl[8]  = '{8'h00, 0, 1'b1};
        tbl[9]  = '{8'h04, 1, 1'b1};
        tbl[10] = '{8'h00, 0, 1'b1};
        tbl[11] = '{8'h00, 0, 1'b1};
        tbl[12] = '{8'h00, 0, 1'b1};
        tbl[13] = '{8'h00, 0, 1'b1};
        model_reset();

        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_req", {31'd0, dp_req}, 32'd0);
        chk("rst_valid", {31'd0, spk_valid}, 32'd0);
        chk("rst_drop", {31'd0, spk_drop}, 32'd0);
        chk("rst_ovr", {31'd0, tick_overrun}, 32'd0);
        chk("rst_addr", 32'(cur_addr), 32'd0);
        chk("rst_dpv", 32'(dp_v), 32'd0);
        chk("rst_dpi", 32'(dp_i), 32'd0);
        chk("rst_spkid", 32'(spk_id), 32'd0);
        reset = 1'b0;

        for (int p = 0; p < 14; p++) begin
            run_pass(tbl[p].mask, 0);
            chk($sformatf("drop_p%0d", p), {31'd0, spk_drop}, {31'd0, tbl[p].exp_drop});
            drain(tbl[p].exp_queued);
        end

        chk("ovr_before", {31'd0, tick_overrun}, 32'd0);
        run_pass(8'h00, 5);
        chk("ovr_after", {31'd0, tick_overrun}, 32'd1);

        dp_ack = 1'b0;
        mask = 8'h00;
        @(posedge clock); #1 tick = 1'b1;
        @(posedge clock); #1 tick = 1'b0;
        for (int k = 0; k < 10 && !dp_req; k++) begin
            @(posedge clock); #1;
        end
        chk("req_stall", {31'd0, dp_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req", {31'd0, dp_req}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_drop", {31'd0, spk_drop}, 32'd0);
        chk("arst_ovr", {31'd0, tick_overrun}, 32'd0);
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        dp_ack = 1'b1;
        run_pass(8'h00, 0);
        drain(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
